// File: rtl/register_file.sv
// Two-read, one-write register file with a hardwired-zero register 0,
// write-through bypass on both read ports and a saturating commit counter.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWrite,
    input  logic [ADDR_WIDTH-1:0] writeReg,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic [ADDR_WIDTH-1:0] readReg1,
    input  logic [ADDR_WIDTH-1:0] readReg2,
    output logic [DATA_WIDTH-1:0] readData1,
    output logic [DATA_WIDTH-1:0] readData2,
    output logic [15:0]           writeCount
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [15:0]           count_q;
    logic [15:0]           count_d;
    logic                  write_en;

    // A write commits only outside reset and never to register 0.
    assign write_en = RegWrite && !rst && (writeReg != '0);

    // NOTE: every always_comb output gets a default before any branch,
    // otherwise an untaken path holds its old value and infers a latch.
    always_comb begin
        regs_d  = regs_q;
        count_d = count_q;
        if (write_en) begin
            regs_d[writeReg] = writeData;
            if (count_q != COUNT_MAX) begin
                count_d = count_q + 16'd1;
            end
        end
    end

    // NOTE: the whole storage array is cleared by reset here because the
    // architecture requires zeroed registers; plain RAMs normally are not reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                // NOTE: sequential state uses non-blocking assignment so all
                // flops update together from pre-edge values.
                regs_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            regs_q  <= regs_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        readData1 = '0;
        if (readReg1 != '0) begin
            if (write_en && (readReg1 == writeReg)) begin
                readData1 = writeData;
            end else begin
                readData1 = regs_q[readReg1];
            end
        end
    end

    always_comb begin
        readData2 = '0;
        if (readReg2 != '0) begin
            if (write_en && (readReg2 == writeReg)) begin
                readData2 = writeData;
            end else begin
                readData2 = regs_q[readReg2];
            end
        end
    end

    assign writeCount = count_q;

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of each register and data port.
REQ-002 Parameter ADDR_WIDTH, default 5, register index width; depth = 2**ADDR_WIDTH (32).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 RegWrite  input  1  write enable from the write-back stage.
REQ-006 writeReg  input  ADDR_WIDTH  destination register index.
REQ-007 writeData  input  DATA_WIDTH  write-back value (MemtoReg-selected readData or ALUResult).
REQ-008 readReg1  input  ADDR_WIDTH  source index, port 1 (rs).
REQ-009 readReg2  input  ADDR_WIDTH  source index, port 2 (rt).
REQ-010 readData1  output  DATA_WIDTH  register value, port 1.
REQ-011 readData2  output  DATA_WIDTH  register value, port 2.
REQ-012 writeCount  output  16  number of committed writes since reset, saturating.

Function
REQ-013 Storage: 2**ADDR_WIDTH registers of DATA_WIDTH bits each.
REQ-014 Write: on a rising clk edge with rst=0, RegWrite=1 and writeReg!=0, register[writeReg] <= writeData.
REQ-015 Register 0: hardwired zero; writes to index 0 are discarded and do not change storage.
REQ-016 Reads: readData1/readData2 are combinational from readReg1/readReg2, zero-cycle latency.
REQ-017 Read of index 0: output is 0 regardless of any pending write to index 0.
REQ-018 Write-through bypass: when RegWrite=1, writeReg!=0 and readRegN==writeReg in the same cycle, readDataN equals writeData (not the stale stored value).
REQ-019 Bypass applies independently to both ports; both ports may bypass in the same cycle.
REQ-020 RegWrite=0: no storage change; no bypass; outputs reflect stored values.
REQ-021 writeCount increments by 1 on every edge where a write per REQ-014 commits; writes to index 0 do not count.
REQ-022 writeCount saturates at 16'hFFFF and holds; no wrap-around.
REQ-023 X/undefined index inputs with RegWrite=0 have no effect on storage.

Reset
REQ-024 On a rising clk edge with rst=1, all registers <= 0 and writeCount <= 0.
REQ-025 rst has priority over RegWrite; a write presented in the reset cycle is dropped and not counted.
REQ-026 During rst=1, the bypass path is suppressed; readData1/readData2 show stored values (0 after the first reset edge).
REQ-027 Reset asserted mid-operation clears all prior contents on the next edge; the first post-reset write commits on the first edge with rst=0.

Verification
REQ-028 Reset, then read all 32 indices on both ports -> every readData1/readData2 = 0, writeCount = 0.
REQ-029 Write 13 to reg 8, then 23 to reg 9; read readReg1=8, readReg2=9 -> readData1=13, readData2=23, writeCount=2.
REQ-030 RegWrite=1, writeReg=0, writeData=32'hDEADBEEF; readReg1=0 -> readData1=0 same and next cycle; writeCount unchanged.
REQ-031 Reg 5 holds 7; same cycle RegWrite=1, writeReg=5, writeData=99, readReg1=readReg2=5 -> both outputs 99 that cycle, 99 thereafter.
REQ-032 Reg 3 = 44; assert rst with simultaneous write 55 to reg 4 -> after edge reg 3=0, reg 4=0, writeCount=0.
REQ-033 Preload writeCount to 16'hFFFE via 65534 writes, then 3 more writes -> writeCount = 16'hFFFF and holds.
